// File: rtl/bw_mac_accumulator.sv
// bw_mac_accumulator
// Signed multiply-accumulate stage that sits after the 4x4 Baugh-Wooley
// multiplier. Product terms are summed per vector into a wide signed
// accumulator, and the result is held on a valid/ready output port.
// Optional build macro: BW_MAC_SAT_EN clamps an overflowing sum to the
// signed limits instead of letting it wrap.
module bw_mac_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = $clog2(MAX_TERMS) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] prod,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic signed [ACC_W-1:0]  outData_q, outData_d;
  logic [CNT_W-1:0]         outCount_q, outCount_d;
  logic                     outOvf_q, outOvf_d;

  logic signed [ACC_W-1:0]  prodExt;
  logic signed [ACC_W-1:0]  rawSum;
  logic signed [ACC_W-1:0]  sumVal;
  logic                     addOvf;
  logic [CNT_W-1:0]         cntNext;
  logic                     isLast;
  logic                     accept;

  // Readiness depends on state alone so upstream never sees a loop through in_valid.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_data  = outData_q;
  assign out_count = outCount_q;
  assign out_ovf   = outOvf_q;

  assign accept  = in_valid && in_ready;
  assign cntNext = cnt_q + CNT_W'(1);
  assign isLast  = in_last || (cntNext == CNT_W'(MAX_TERMS));

  // Sign-extend the product, add it to the running sum and flag a signed overflow.
  always_comb begin
    prodExt = ACC_W'(prod);
    rawSum  = acc_q + prodExt;
    addOvf  = (acc_q[ACC_W-1] == prodExt[ACC_W-1]) &&
              (rawSum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef BW_MAC_SAT_EN
    if (addOvf) begin
      sumVal = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sumVal = rawSum;
    end
`else
    sumVal = rawSum;
`endif
  end

  // Next-state and datapath update: accumulate terms, close the vector, hold the result.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    outData_d  = outData_q;
    outCount_d = outCount_q;
    outOvf_d   = outOvf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (isLast) begin
            outData_d  = sumVal;
            outCount_d = cntNext;
            outOvf_d   = ovf_q || addOvf;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            state_d    = HOLD;
          end else begin
            acc_d   = sumVal;
            cnt_d   = cntNext;
            ovf_d   = ovf_q || addOvf;
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial sum and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      outData_q  <= '0;
      outCount_q <= '0;
      outOvf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      outData_q  <= outData_d;
      outCount_q <= outCount_d;
      outOvf_q   <= outOvf_d;
    end
  end

endmodule

// File: tb/tb_bw_mac_accumulator.sv
// tb_bw_mac_accumulator
// Two instances: index 0 uses the default widths (ACC_W=16, MAX_TERMS=16),
// index 1 uses a narrow accumulator (ACC_W=8, MAX_TERMS=4) so that overflow
// and forced-last are easy to reach. A transaction-level model predicts the
// outputs of both, and directed vectors carry hand-computed results.
// Build macro BW_MAC_SAT_EN selects the clamping expectation.
module tb_bw_mac_accumulator;

  logic       clk;
  logic       rst_n;
  logic       inValid [2];
  logic [7:0] prodIn [2];
  logic       inLast [2];
  logic       outReady [2];
  logic       inReadyW [2];
  logic       outValidW [2];
  logic       outOvfW [2];
  logic [15:0] outDataA;
  logic [7:0]  outDataB;
  logic [4:0]  outCountA;
  logic [2:0]  outCountB;

  int total = 0;
  int bad = 0;

  int accWidth [2] = '{16, 8};
  int maxTerms [2] = '{16, 4};

  // Reference state: running sum as an unbounded integer, pending result.
  int accM [2];
  int cntM [2];
  bit ovfM [2];
  bit holdM [2];
  int expData [2];
  int expCount [2];
  bit expOvf [2];

  bw_mac_accumulator #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16)) dutA (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[0]), .in_ready(inReadyW[0]),
    .prod(prodIn[0]), .in_last(inLast[0]),
    .out_valid(outValidW[0]), .out_ready(outReady[0]),
    .out_data(outDataA), .out_count(outCountA), .out_ovf(outOvfW[0])
  );

  bw_mac_accumulator #(.PROD_W(8), .ACC_W(8), .MAX_TERMS(4)) dutB (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[1]), .in_ready(inReadyW[1]),
    .prod(prodIn[1]), .in_last(inLast[1]),
    .out_valid(outValidW[1]), .out_ready(outReady[1]),
    .out_data(outDataB), .out_count(outCountB), .out_ovf(outOvfW[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int actData(int i);
    if (i == 0) return int'($signed(outDataA));
    return int'($signed(outDataB));
  endfunction

  function automatic int actCount(int i);
    if (i == 0) return int'(outCountA);
    return int'(outCountB);
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: exact integer sum, then range check for overflow and wrap/clamp.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        accM[i] = 0; cntM[i] = 0; ovfM[i] = 0; holdM[i] = 0;
        expData[i] = 0; expCount[i] = 0; expOvf[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (holdM[i]) begin
          if (outReady[i]) holdM[i] = 0;
        end else if (inValid[i]) begin
          int half, full, sum, val, cnt;
          bit o;
          half = 1 << (accWidth[i] - 1);
          full = 1 << accWidth[i];
          sum = accM[i] + int'($signed(prodIn[i]));
          o = (sum > half - 1) || (sum < -half);
`ifdef BW_MAC_SAT_EN
          if (sum > half - 1) val = half - 1;
          else if (sum < -half) val = -half;
          else val = sum;
`else
          val = (((sum + half) % full) + full) % full - half;
`endif
          cnt = cntM[i] + 1;
          if (inLast[i] || cnt == maxTerms[i]) begin
            expData[i] = val; expCount[i] = cnt; expOvf[i] = ovfM[i] | o;
            holdM[i] = 1; accM[i] = 0; cntM[i] = 0; ovfM[i] = 0;
          end else begin
            accM[i] = val; cntM[i] = cnt; ovfM[i] = ovfM[i] | o;
          end
        end
      end
    end
  end

  // Compare both instances against the model every cycle away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("mdl_in_ready%0d", i), int'(inReadyW[i]), int'(!holdM[i]));
        checkOutput($sformatf("mdl_out_valid%0d", i), int'(outValidW[i]), int'(holdM[i]));
        if (holdM[i]) begin
          checkOutput($sformatf("mdl_out_data%0d", i), actData(i), expData[i]);
          checkOutput($sformatf("mdl_out_count%0d", i), actCount(i), expCount[i]);
          checkOutput($sformatf("mdl_out_ovf%0d", i), int'(outOvfW[i]), int'(expOvf[i]));
        end
      end
    end
  end

  // Offer one term and keep it offered until the instance takes it.
  task automatic applyStimulus(int i, logic [7:0] p, logic last);
    int n = 0;
    inValid[i] = 1'b1;
    prodIn[i] = p;
    inLast[i] = last;
    while (!inReadyW[i] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) checkOutput("accept_timeout", 0, 1);
    @(posedge clk); #1;
    inValid[i] = 1'b0;
    inLast[i] = 1'b0;
  endtask

  // Wait (bounded) for a result and compare it with hand-computed values.
  task automatic waitResult(int i, int d, int c, int o);
    int n = 0;
    @(negedge clk);
    while (!outValidW[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lit_valid", int'(outValidW[i]), 1);
    if (outValidW[i]) begin
      checkOutput("lit_data", actData(i), d);
      checkOutput("lit_count", actCount(i), c);
      checkOutput("lit_ovf", int'(outOvfW[i]), o);
    end
  endtask

  task automatic drain(int i);
    outReady[i] = 1'b1;
    @(posedge clk); #1;
    outReady[i] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inValid[i] = 0; prodIn[i] = 0; inLast[i] = 0; outReady[i] = 0;
    end
    #3;
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_valid", int'(outValidW[i]), 0);
      checkOutput("rst_data", actData(i), 0);
      checkOutput("rst_count", actCount(i), 0);
      checkOutput("rst_ovf", int'(outOvfW[i]), 0);
    end
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_ready0", int'(inReadyW[0]), 1);
    checkOutput("rst_ready1", int'(inReadyW[1]), 1);

    // Single term: -8 * -8 = 64
    applyStimulus(0, 8'h40, 1);
    waitResult(0, 64, 1, 0);
    drain(0);

    // Three terms: 64 - 56 + 7 = 15
    applyStimulus(0, 8'h40, 0);
    applyStimulus(0, 8'hC8, 0);
    applyStimulus(0, 8'h07, 1);
    waitResult(0, 15, 3, 0);
    drain(0);

    // Narrow accumulator overflow: 64 + 64
    applyStimulus(1, 8'h40, 0);
    applyStimulus(1, 8'h40, 1);
`ifdef BW_MAC_SAT_EN
    waitResult(1, 127, 2, 1);
`else
    waitResult(1, -128, 2, 1);
`endif
    drain(1);
    applyStimulus(1, 8'h01, 1);
    waitResult(1, 1, 1, 0);
    drain(1);

    // Backpressure: hold a result while a new term waits upstream
    applyStimulus(0, 8'h05, 1);
    waitResult(0, 5, 1, 0);
    inValid[0] = 1'b1; prodIn[0] = 8'h05; inLast[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_ready", int'(inReadyW[0]), 0);
      checkOutput("bp_valid", int'(outValidW[0]), 1);
      checkOutput("bp_data", actData(0), 5);
    end
    outReady[0] = 1'b1;
    @(posedge clk); #1;
    outReady[0] = 1'b0;
    checkOutput("bp_valid_drop", int'(outValidW[0]), 0);
    checkOutput("bp_ready_rise", int'(inReadyW[0]), 1);
    applyStimulus(0, 8'h05, 1);
    waitResult(0, 5, 1, 0);
    drain(0);

    // Forced last on both term limits
    for (int k = 0; k < 4; k++) applyStimulus(1, 8'h01, 0);
    waitResult(1, 4, 4, 0);
    drain(1);
    for (int k = 0; k < 16; k++) applyStimulus(0, 8'hFF, 0);
    waitResult(0, -16, 16, 0);
    drain(0);

    // Reset with a pending result on one instance and a partial sum on the other
    applyStimulus(1, 8'h03, 1);
    waitResult(1, 3, 1, 0);
    applyStimulus(0, 8'h10, 0);
    applyStimulus(0, 8'h10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("mid_rst_valid", int'(outValidW[i]), 0);
      checkOutput("mid_rst_data", actData(i), 0);
      checkOutput("mid_rst_count", actCount(i), 0);
      checkOutput("mid_rst_ovf", int'(outOvfW[i]), 0);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    applyStimulus(0, 8'h02, 1);
    waitResult(0, 2, 1, 0);
    drain(0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
